// File: rtl/i_type_alu_mc.sv
// rtl/i_type_alu_mc.sv - multi-cycle RV32I/RV64I I-type execute unit with iterative shifter
// Optional macro IALU_ILLEGAL_EN adds illegal-shift-encoding detection and the illegal_op port.
module i_type_alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [XLEN-1:0] rv1,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_data,
`ifdef IALU_ILLEGAL_EN
    output logic            illegal_op,
`endif
    output logic            busy
);

    localparam int LOG = $clog2(XLEN);
    localparam int CW  = LOG + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    localparam logic [1:0] K_SLL = 2'd0;
    localparam logic [1:0] K_SRL = 2'd1;
    localparam logic [1:0] K_SRA = 2'd2;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      kind_q, kind_d;

    logic [LOG-1:0]  sh;
    logic            is_shift;
    logic            illegal;
    logic [XLEN-1:0] alu_res;
    logic [CW-1:0]   step;
    logic [XLEN-1:0] shifted;

    assign sh        = imm[LOG-1:0];
    assign is_shift  = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign in_ready  = (state_q == IDLE) && !reset;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign rd_data   = rd_q;

`ifdef IALU_ILLEGAL_EN
    localparam logic [11:0] SH_MASK = 12'((1 << LOG) - 1);
    logic [11:0] imm_hi;
    logic        illegal_q, illegal_d;

    // Bits above the shift amount must match the canonical SLLI/SRLI/SRAI encoding.
    assign imm_hi  = imm[11:0] & ~SH_MASK;
    assign illegal = ((funct3 == 3'b001) && (funct7_5 || (imm_hi != 12'h000))) ||
                     ((funct3 == 3'b101) && (imm_hi != (funct7_5 ? 12'h400 : 12'h000)));
    assign illegal_op = illegal_q;

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == IDLE && in_valid)
            illegal_d = illegal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        alu_res = rv1;
        case (funct3)
            3'b000:  alu_res = rv1 + imm;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rv1) < $signed(imm))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (rv1 < imm)};
            3'b100:  alu_res = rv1 ^ imm;
            3'b110:  alu_res = rv1 | imm;
            3'b111:  alu_res = rv1 & imm;
            default: alu_res = rv1;
        endcase
    end

    always_comb begin
        step = (cnt_q < STEP_C) ? cnt_q : STEP_C;
        case (kind_q)
            K_SLL:   shifted = acc_q << step;
            K_SRA:   shifted = XLEN'($signed(acc_q) >>> step);
            default: shifted = acc_q >> step;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        kind_d  = kind_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    kind_d = (funct3 == 3'b001) ? K_SLL : (funct7_5 ? K_SRA : K_SRL);
                    if (illegal) begin
                        rd_d    = '0;
                        state_d = DONE;
                    end else if (is_shift && (sh != '0)) begin
                        acc_d   = rv1;
                        cnt_d   = {1'b0, sh};
                        state_d = SHIFT;
                    end else begin
                        rd_d    = alu_res;
                        state_d = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = shifted;
                cnt_d = cnt_q - step;
                if (cnt_q == step) begin
                    rd_d    = shifted;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            kind_q  <= K_SLL;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            kind_q  <= kind_d;
        end
    end

endmodule

// File: tb/tb_i_type_alu_mc.sv
// tb/tb_i_type_alu_mc.sv - directed self-checking bench for i_type_alu_mc (SHIFT_STEP 1 and 4)
module tb_i_type_alu_mc;

`ifdef IALU_ILLEGAL_EN
    localparam logic [31:0] SRAI_IMM3 = 32'h0000_0403;
    localparam logic [31:0] SLLI_IMM  = 32'd14;
`else
    localparam logic [31:0] SRAI_IMM3 = 32'd3;
    localparam logic [31:0] SLLI_IMM  = 32'd750;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] rv1, imm;
    logic        in_valid_a, in_valid_b, out_ready_a, out_ready_b;
    logic        in_ready_a, in_ready_b, out_valid_a, out_valid_b, busy_a, busy_b;
    logic [31:0] rd_a, rd_b;
    logic        sel;
    int          checks, errors;

    always #5 clk = ~clk;

`ifdef IALU_ILLEGAL_EN
    logic ill_a, ill_b;
    wire  ill_s = sel ? ill_b : ill_a;
`endif

    i_type_alu_mc #(.XLEN(32), .SHIFT_STEP(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .funct3(funct3), .funct7_5(funct7_5), .rv1(rv1), .imm(imm),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .rd_data(rd_a),
`ifdef IALU_ILLEGAL_EN
        .illegal_op(ill_a),
`endif
        .busy(busy_a)
    );

    i_type_alu_mc #(.XLEN(32), .SHIFT_STEP(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .funct3(funct3), .funct7_5(funct7_5), .rv1(rv1), .imm(imm),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .rd_data(rd_b),
`ifdef IALU_ILLEGAL_EN
        .illegal_op(ill_b),
`endif
        .busy(busy_b)
    );

    wire        ov_s   = sel ? out_valid_b : out_valid_a;
    wire        busy_s = sel ? busy_b : busy_a;
    wire [31:0] rd_s   = sel ? rd_b : rd_a;

    // Offers one op for a single cycle, then scrambles the operands; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] f3, input logic f7, input logic [31:0] r, input logic [31:0] i);
        @(negedge clk);
        funct3 = f3; funct7_5 = f7; rv1 = r; imm = i;
        if (sel) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        @(negedge clk);
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        funct3 = 3'b000; funct7_5 = 1'b1; rv1 = 32'hDEAD_BEEF; imm = 32'h0000_0005;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!ov_s && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if (in_ready_a !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready_a); end
        checks++; if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b%b exp 00", out_valid_a, out_valid_b); end
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL rst_busy got %b%b exp 00", busy_a, busy_b); end
        checks++; if (rd_a !== 32'd0 || rd_b !== 32'd0) begin errors++; $display("FAIL rst_rd_data got %h %h exp 0", rd_a, rd_b); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready_a); end
    endtask

    task automatic test_addi;
        sel = 1'b0;
        issue(3'b000, 1'b0, 32'd617, 32'd511);
        checks++; if (ov_s !== 1'b1) begin errors++; $display("FAIL addi_latency out_valid got %b exp 1", ov_s); end
        checks++; if (rd_s !== 32'd1128) begin errors++; $display("FAIL addi_data got %0d exp 1128", rd_s); end
        checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL addi_busy got %b exp 1", busy_s); end
        @(negedge clk);
        checks++; if (busy_s !== 1'b0 || ov_s !== 1'b0) begin errors++; $display("FAIL addi_drain busy/out_valid got %b%b exp 00", busy_s, ov_s); end
    endtask

    task automatic test_slt;
        int lat;
        sel = 1'b0;
        issue(3'b011, 1'b0, 32'd980, 32'hFFFF_FFFF);
        wait_out(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL sltiu_latency got %0d exp 1", lat); end
        checks++; if (rd_s !== 32'd1) begin errors++; $display("FAIL sltiu_data got %0d exp 1", rd_s); end
        issue(3'b010, 1'b0, 32'd980, 32'hFFFF_FFFF);
        wait_out(lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL slti_latency got %0d exp 1", lat); end
        checks++; if (rd_s !== 32'd0) begin errors++; $display("FAIL slti_data got %0d exp 0", rd_s); end
    endtask

    task automatic test_logic;
        int lat;
        sel = 1'b0;
        issue(3'b100, 1'b0, 32'h0F0F_1234, 32'hFFFF_F0F0);
        wait_out(lat);
        checks++; if (rd_s !== 32'hF0F0_E2C4) begin errors++; $display("FAIL xori_data got %h exp f0f0e2c4", rd_s); end
        issue(3'b110, 1'b0, 32'h0F0F_1234, 32'hFFFF_F0F0);
        wait_out(lat);
        checks++; if (rd_s !== 32'hFFFF_F2F4) begin errors++; $display("FAIL ori_data got %h exp fffff2f4", rd_s); end
        issue(3'b111, 1'b1, 32'h0F0F_1234, 32'hFFFF_F0F0);
        wait_out(lat);
        checks++; if (rd_s !== 32'h0F0F_1030) begin errors++; $display("FAIL andi_data got %h exp 0f0f1030", rd_s); end
        issue(3'b000, 1'b1, 32'hFFFF_FFFF, 32'd2);
        wait_out(lat);
        checks++; if (rd_s !== 32'd1) begin errors++; $display("FAIL addi_wrap got %h exp 00000001", rd_s); end
    endtask

    task automatic test_srai_srli;
        int lat;
        sel = 1'b0;
        issue(3'b101, 1'b1, -32'sd949, SRAI_IMM3);
        wait_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL srai_latency got %0d exp 4", lat); end
        checks++; if (rd_s !== -32'sd119) begin errors++; $display("FAIL srai_data got %h exp %h", rd_s, -32'sd119); end
        issue(3'b101, 1'b0, -32'sd949, 32'd3);
        wait_out(lat);
        checks++; if (lat != 4) begin errors++; $display("FAIL srli_latency got %0d exp 4", lat); end
        checks++; if (rd_s !== 32'h1FFF_FF89) begin errors++; $display("FAIL srli_data got %h exp 1fffff89", rd_s); end
        issue(3'b001, 1'b0, 32'h0000_1234, 32'd0);
        wait_out(lat);
        checks++; if (lat != 1 || rd_s !== 32'h0000_1234) begin errors++; $display("FAIL slli_sh0 got lat %0d data %h exp lat 1 data 00001234", lat, rd_s); end
    endtask

    task automatic test_slli_hold;
        int lat;
        logic [31:0] held;
        sel = 1'b1;
        out_ready_b = 1'b0;
        issue(3'b001, 1'b0, 32'd843, SLLI_IMM);
        wait_out(lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL slli_latency got %0d exp 5", lat); end
        checks++; if (rd_s !== 32'd13811712) begin errors++; $display("FAIL slli_data got %0d exp 13811712", rd_s); end
        held = rd_s;
        funct3 = 3'b000; funct7_5 = 1'b0; rv1 = 32'd1; imm = 32'd1;
        in_valid_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rd_b !== held || in_ready_b !== 1'b0 || out_valid_b !== 1'b1) begin
                errors++;
                $display("FAIL hold_cycle%0d got rd %h in_ready %b out_valid %b exp rd %h in_ready 0 out_valid 1", k, rd_b, in_ready_b, out_valid_b, held);
            end
        end
        out_ready_b = 1'b1;
        @(negedge clk);
        checks++; if (out_valid_b !== 1'b0 || busy_b !== 1'b0 || in_ready_b !== 1'b1) begin errors++; $display("FAIL handshake_idle got ov %b busy %b in_ready %b exp 0 0 1", out_valid_b, busy_b, in_ready_b); end
        @(negedge clk);
        in_valid_b = 1'b0;
        checks++; if (out_valid_b !== 1'b1 || rd_b !== 32'd2) begin errors++; $display("FAIL back_to_back got ov %b rd %h exp 1 00000002", out_valid_b, rd_b); end
        @(negedge clk);
    endtask

    task automatic test_step4_bounds;
        int lat;
        sel = 1'b1;
        issue(3'b101, 1'b1, 32'h8000_0000, 32'h0000_0408);
        wait_out(lat);
        checks++; if (lat != 3) begin errors++; $display("FAIL srai8_latency got %0d exp 3", lat); end
        checks++; if (rd_s !== 32'hFF80_0000) begin errors++; $display("FAIL srai8_data got %h exp ff800000", rd_s); end
        issue(3'b001, 1'b0, 32'd1, 32'd31);
        wait_out(lat);
        checks++; if (lat != 9) begin errors++; $display("FAIL slli31_latency got %0d exp 9", lat); end
        checks++; if (rd_s !== 32'h8000_0000) begin errors++; $display("FAIL slli31_data got %h exp 80000000", rd_s); end
    endtask

    task automatic test_reset_mid;
        int seen;
        sel = 1'b0;
        issue(3'b001, 1'b0, 32'd1, 32'd20);
        @(negedge clk);
        checks++; if (busy_a !== 1'b1 || out_valid_a !== 1'b0) begin errors++; $display("FAIL mid_shift got busy %b ov %b exp 1 0", busy_a, out_valid_a); end
        reset = 1'b1;
        #1;
        checks++; if (out_valid_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== 32'd0 || in_ready_a !== 1'b0) begin errors++; $display("FAIL mid_reset got ov %b busy %b rd %h in_ready %b exp 0 0 0 0", out_valid_a, busy_a, rd_a, in_ready_a); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got %b exp 1", in_ready_a); end
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_valid_a) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_result got %0d out_valid cycles exp 0", seen); end
    endtask

`ifdef IALU_ILLEGAL_EN
    task automatic test_illegal;
        int lat;
        sel = 1'b1;
        issue(3'b001, 1'b0, 32'd5, 32'h0000_0420);
        wait_out(lat);
        checks++; if (lat != 1 || rd_s !== 32'd0 || ill_s !== 1'b1) begin errors++; $display("FAIL ill_slli got lat %0d rd %h ill %b exp 1 0 1", lat, rd_s, ill_s); end
        issue(3'b101, 1'b1, -32'sd949, 32'h0000_0403);
        wait_out(lat);
        checks++; if (lat != 2 || rd_s !== -32'sd119 || ill_s !== 1'b0) begin errors++; $display("FAIL ill_srai_legal got lat %0d rd %h ill %b exp 2 ffffff89 0", lat, rd_s, ill_s); end
        issue(3'b001, 1'b1, 32'd7, 32'd2);
        wait_out(lat);
        checks++; if (lat != 1 || rd_s !== 32'd0 || ill_s !== 1'b1) begin errors++; $display("FAIL ill_slli_f7 got lat %0d rd %h ill %b exp 1 0 1", lat, rd_s, ill_s); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        out_ready_a = 1'b1; out_ready_b = 1'b1;
        funct3 = 3'b000; funct7_5 = 1'b0; rv1 = '0; imm = '0;
        sel = 1'b0;
        test_reset;
        test_addi;
        test_slt;
        test_logic;
        test_srai_srli;
        test_slli_hold;
        test_step4_bounds;
        test_reset_mid;
`ifdef IALU_ILLEGAL_EN
        test_illegal;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
